// File: rtl/karatsuba_poly_reducer.sv
// Karatsuba product reducer: folds a (2D-1)-coefficient product into D
// coefficients modulo x^D + 1 (negacyclic) or x^D - 1 (cyclic).
// LANES coefficients are folded per cycle. Handshakes are valid/ready on both sides.

// One fold lane: r_j = p_j -/+ p_(j+D), computed at N+1 bits and truncated to N bits.
module karatsuba_fold_lane #(
    parameter int N          = 8,
    parameter int NEGACYCLIC = 1
) (
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    output logic [N-1:0] res
);
    logic [N:0] full;
    logic       unused_carry;

    assign full         = (NEGACYCLIC != 0) ? ({1'b0, lo} - {1'b0, hi})
                                            : ({1'b0, lo} + {1'b0, hi});
    assign res          = full[N-1:0];
    assign unused_carry = full[N];
endmodule

module karatsuba_poly_reducer #(
    parameter int D          = 16,
    parameter int N          = 8,
    parameter int LANES      = 4,
    parameter int NEGACYCLIC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [(2*D-1)*N-1:0]   p,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [D*N-1:0]         r,
    output logic                   busy
);
    localparam int STEPS = D / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = (2*D-1) * N;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [PW-1:0]             p_q;
    // p_(2D-1) does not exist; a zero coefficient on top makes r_(D-1) = p_(D-1)
    logic [2*D*N-1:0]          p_ext;
    logic [LANES-1:0][N-1:0]   lane_res;

    assign p_ext = {{N{1'b0}}, p_q};

    // Per-lane fold of the coefficient chunk selected by cnt
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [N-1:0] lo;
        logic [N-1:0] hi;

        assign lo = p_ext[(int'(cnt)*LANES + k)*N     +: N];
        assign hi = p_ext[(int'(cnt)*LANES + k + D)*N +: N];

        karatsuba_fold_lane #(.N(N), .NEGACYCLIC(NEGACYCLIC)) u_lane (
            .lo  (lo),
            .hi  (hi),
            .res (lane_res[k])
        );
    end

    // Control FSM with registered handshake outputs; r is written chunk by chunk in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            p_q       <= '0;
            r         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p_q      <= p;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r[int'(cnt)*LANES*N +: LANES*N] <= lane_res;
                    if (cnt == CW'(STEPS-1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_poly_reducer.sv
// Directed bench for karatsuba_poly_reducer: a negacyclic and a cyclic instance
// share one stimulus and are checked against hand-derived expected rings.
module tb_karatsuba_poly_reducer;
    localparam int D     = 16;
    localparam int N     = 8;
    localparam int LANES = 4;
    localparam int PW    = (2*D-1)*N;
    localparam int RW    = D*N;

    typedef struct {
        logic [PW-1:0] p;
        logic [RW-1:0] rn;
        logic [RW-1:0] rc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] p = '0;
    logic          in_ready_n, out_valid_n, busy_n;
    logic          in_ready_c, out_valid_c, busy_c;
    logic [RW-1:0] r_n, r_c;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[5];

    always #5 clk = ~clk;

    karatsuba_poly_reducer #(.D(D), .N(N), .LANES(LANES), .NEGACYCLIC(1)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .p(p),
        .out_valid(out_valid_n), .out_ready(out_ready), .r(r_n), .busy(busy_n)
    );

    karatsuba_poly_reducer #(.D(D), .N(N), .LANES(LANES), .NEGACYCLIC(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .p(p),
        .out_valid(out_valid_c), .out_ready(out_ready), .r(r_c), .busy(busy_c)
    );

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // {in_ready, out_valid, busy} for both instances
    task automatic chk_ctl(input string name, input logic [2:0] exp);
        chk({name, "_ctl_neg"}, RW'({in_ready_n, out_valid_n, busy_n}), RW'(exp));
        chk({name, "_ctl_cyc"}, RW'({in_ready_c, out_valid_c, busy_c}), RW'(exp));
    endtask

    task automatic chk_r(input string name, input logic [RW-1:0] en, input logic [RW-1:0] ec);
        chk({name, "_r_neg"}, r_n, en);
        chk({name, "_r_cyc"}, r_c, ec);
    endtask

    // Count edges until out_valid, bounded; lat starts at 'start'
    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!out_valid_n && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept(input string name, input logic [PW-1:0] pv);
        chk_ctl({name, "_pre"}, 3'b100);
        in_valid = 1'b1;
        p = pv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_ctl({name, "_acc"}, 3'b001);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_ctl({name, "_hs"}, 3'b100);
    endtask

    initial begin
        logic [PW-1:0] pv;
        logic [RW-1:0] en, ec;
        logic [RW-1:0] zero_r;
        int lat;
        bit seen;

        zero_r = '0;

        // Triangle product from a = b = all-ones coefficients
        pv = '0; en = '0; ec = '0;
        for (int k = 0; k < 2*D-1; k++) pv[k*N +: N] = (k < 16) ? 8'(k + 1) : 8'(31 - k);
        for (int j = 0; j < D; j++) begin
            en[j*N +: N] = 8'(2*j - 14);
            ec[j*N +: N] = 8'h10;
        end
        vecs[0] = '{pv, en, ec};

        // Negacyclic borrow wrap: 0 - 1
        pv = '0; en = '0; ec = '0;
        pv[16*N +: N] = 8'h01;
        en[7:0] = 8'hFF; ec[7:0] = 8'h01;
        vecs[1] = '{pv, en, ec};

        // Cyclic carry wrap: 0xFF + 0x02
        pv = '0; en = '0; ec = '0;
        pv[7:0] = 8'hFF; pv[16*N +: N] = 8'h02;
        en[7:0] = 8'hFD; ec[7:0] = 8'h01;
        vecs[2] = '{pv, en, ec};

        // Top boundary: last pair j=14 and unpaired j=15
        pv = '0; en = '0; ec = '0;
        pv[14*N +: N] = 8'h10; pv[30*N +: N] = 8'hCD; pv[15*N +: N] = 8'hAB;
        en[14*N +: N] = 8'h43; ec[14*N +: N] = 8'hDD;
        en[15*N +: N] = 8'hAB; ec[15*N +: N] = 8'hAB;
        vecs[3] = '{pv, en, ec};

        // Mid-ring lane, both rings produce 0x10 via wrap
        pv = '0; en = '0; ec = '0;
        pv[3*N +: N] = 8'h90; pv[19*N +: N] = 8'h80;
        en[3*N +: N] = 8'h10; ec[3*N +: N] = 8'h10;
        vecs[4] = '{pv, en, ec};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_ctl("reset", 3'b100);
        chk_r("reset", zero_r, zero_r);
        rst = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 5; i++) begin
            accept($sformatf("v%0d", i), vecs[i].p);
            wait_out(0, lat);
            chk($sformatf("v%0d_latency", i), RW'(lat), RW'(4));
            chk_ctl($sformatf("v%0d_done", i), 3'b011);
            chk_r($sformatf("v%0d", i), vecs[i].rn, vecs[i].rc);
            handshake($sformatf("v%0d", i));
            chk_r($sformatf("v%0d_held", i), vecs[i].rn, vecs[i].rc);
        end

        // Backpressure: out_ready low for 5 cycles after out_valid
        accept("bp", vecs[0].p);
        wait_out(0, lat);
        chk("bp_latency", RW'(lat), RW'(4));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk_ctl($sformatf("bp_hold%0d", c), 3'b011);
            chk_r($sformatf("bp_hold%0d", c), vecs[0].rn, vecs[0].rc);
        end
        handshake("bp");

        // Back-to-back with in_valid held; p changes during the first RUN
        in_valid = 1'b1;
        p = vecs[0].p;
        @(posedge clk); #1;
        chk_ctl("b2b_acc1", 3'b001);
        @(posedge clk); #1;
        p = vecs[1].p;
        wait_out(1, lat);
        chk("b2b_latency1", RW'(lat), RW'(4));
        chk_r("b2b_first", vecs[0].rn, vecs[0].rc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_ctl("b2b_idle", 3'b100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_ctl("b2b_acc2", 3'b001);
        wait_out(0, lat);
        chk("b2b_latency2", RW'(lat), RW'(4));
        chk_r("b2b_second", vecs[1].rn, vecs[1].rc);
        handshake("b2b");

        // Reset during the second RUN cycle
        accept("abort", vecs[0].p);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_ctl("abort", 3'b100);
        chk_r("abort", zero_r, zero_r);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid_n || out_valid_c) seen = 1'b1;
        end
        chk("abort_no_out", RW'(seen), RW'(0));

        // Recovery after abort
        accept("recover", vecs[3].p);
        wait_out(0, lat);
        chk("recover_latency", RW'(lat), RW'(4));
        chk_r("recover", vecs[3].rn, vecs[3].rc);
        handshake("recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
